serpent_decrypt_core: RTL and testbench
=======================================

SERPENT_DECRYPT_CORE -- requirements
Module: serpent_decrypt_core

Interface
REQ-001 The block SHALL use one clock, clk; the reset SHALL be rst_n, asynchronous and active-low.
REQ-002 Ports SHALL be, one per line, as follows.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  ciphertext offered.
- in_ready  out  1  block can accept.
- input_data  in  128  ciphertext; word k = bits [32k+31:32k].
- key_idx  out  6  subkey index requested, 0..32.
- subkey  in  128  K[key_idx], valid in the same cycle, combinational from the key store.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts.
- output_data  out  128  plaintext.
REQ-003 There SHALL be no parameters; rounds are fixed at 32 and subkeys at 33.

Function
REQ-004 Bitslice mapping: nibble i (i=0..31) SHALL be {word3[i],word2[i],word1[i],word0[i]}, matching the encrypt S-box layers.
REQ-005 FSM states SHALL be IDLE, ROUND and DONE.
REQ-006 IDLE behaviour:
- in_ready=1, key_idx=32.
- On in_valid&in_ready, load state <= input_data ^ subkey, set rnd <= 31 and go to ROUND.
REQ-007 ROUND at rnd=31: key_idx=31; state <= InvS7(state) ^ subkey; rnd <= 30.
REQ-008 ROUND at rnd=r<31: key_idx=r; state <= InvS_(r mod 8)(InvLT(state)) ^ subkey.
- r>0: rnd <= r-1.
- r=0: go to DONE.
REQ-009 InvLT on words X0..X3, with rotr = rotate right:
- X2=rotr(X2,22); X0=rotr(X0,5);
- X2^=X3^(X1<<7); X0^=X1^X3;
- X3=rotr(X3,7); X1=rotr(X1,1);
- X3^=X2^(X0<<3); X1^=X0^X2;
- X2=rotr(X2,3); X0=rotr(X0,13).
REQ-010 InvS0..InvS7 SHALL be the exact inverses of encrypt S0..S7 (e.g. InvS0 = 13,3,11,0,10,6,5,12,1,14,4,7,15,9,8,2).
REQ-011 DONE behaviour:
- out_valid=1, output_data=state, key_idx=0.
- output_data SHALL hold stable while out_valid&!out_ready.
- On out_ready, return to IDLE.
REQ-012 Latency: with acceptance in cycle 0, out_valid SHALL be high in cycle 33 (32 ROUND cycles). With out_ready held high, throughput is one block per 34 cycles.
REQ-013 in_ready SHALL be 0 in ROUND and DONE; in_valid there SHALL be ignored and not queued.
REQ-014 output_data SHALL read 0 whenever out_valid=0.
REQ-015 The subkey bus SHALL be sampled only in the cycle key_idx requests it; subkey changes in other cycles SHALL have no effect.

Reset
REQ-016 rst_n low at any time, including mid-ROUND or in DONE, SHALL immediately force:
- state IDLE, rnd=31, internal state register=0;
- in_ready=1 after release, out_valid=0, output_data=0, key_idx=32.
The in-flight block SHALL be discarded.

Configuration
REQ-017 With SERPENT_DEC_ABORT_EN defined, an input port abort (1 bit) SHALL exist.
- abort=1 in ROUND or DONE returns the FSM to IDLE next cycle with out_valid=0 and no output produced.
- abort in IDLE SHALL be ignored.
- abort has priority over out_ready.
REQ-018 Without SERPENT_DEC_ABORT_EN the port SHALL be absent and behaviour SHALL be as in REQ-005..REQ-015.

Structure
REQ-019 Shared package serpent_pkg SHALL hold:
- the InvS tables (8x16x4);
- the NUM_ROUNDS=32 and NUM_SUBKEYS=33 constants;
- the InvLT rotate/shift amounts;
- the FSM state typedef.
REQ-020 One sub-module, inv_s4_box_sel, SHALL apply the 32-column bitsliced InvS selected by a 3-bit input. The core SHALL contain no other sub-modules.

Verification
REQ-021 inv_s4_box_sel, sel=0, input 0 -> output words 0xFFFFFFFF,0x00000000,0xFFFFFFFF,0xFFFFFFFF.
REQ-022 Round trip: all 33 subkeys 0, plaintext 0 encrypted by the existing encrypt path, then fed here -> output_data=0 in cycle 33.
REQ-023 Round trip with random subkeys and 1000 random plaintexts -> every output equals its plaintext; key_idx sequence per block is 32,31,...,0.
REQ-024 out_ready held 0 for 10 cycles after out_valid -> output_data stable, in_ready=0, then one cycle after out_ready=1 in_ready=1.
REQ-025 rst_n asserted at rnd=15 -> out_valid=0 and in_ready=1 after release; the next block decrypts correctly.
REQ-026 With SERPENT_DEC_ABORT_EN, abort at rnd=20 -> IDLE next cycle, no out_valid pulse; the following block decrypts correctly.

Source files
------------

// File: rtl/serpent_pkg.sv
// Shared definitions for the Serpent decryption core.
//   INV_SBOX     : inverse S-boxes InvS0..InvS7, indexed [box][nibble]
//   NUM_ROUNDS   : 32 cipher rounds
//   NUM_SUBKEYS  : 33 round subkeys K0..K32
//   INV_LT_*     : rotate/shift amounts of the inverse linear transform
//   dec_state_e  : decrypt FSM state encoding
//   rotr32/inv_lt: helpers for the inverse linear transform
package serpent_pkg;

  localparam int unsigned NUM_ROUNDS  = 32;
  localparam int unsigned NUM_SUBKEYS = 33;

  // Inverse linear transform amounts, in order of application.
  localparam int unsigned INV_LT_ROT_X2_A = 22;
  localparam int unsigned INV_LT_ROT_X0_A = 5;
  localparam int unsigned INV_LT_SHL_X1   = 7;
  localparam int unsigned INV_LT_ROT_X3   = 7;
  localparam int unsigned INV_LT_ROT_X1   = 1;
  localparam int unsigned INV_LT_SHL_X0   = 3;
  localparam int unsigned INV_LT_ROT_X2_B = 3;
  localparam int unsigned INV_LT_ROT_X0_B = 13;

  localparam logic [3:0] INV_SBOX [8][16] = '{
    '{4'hD, 4'h3, 4'hB, 4'h0, 4'hA, 4'h6, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hF, 4'h9, 4'h8, 4'h2},
    '{4'h5, 4'h8, 4'h2, 4'hE, 4'hF, 4'h6, 4'hC, 4'h3, 4'hB, 4'h4, 4'h7, 4'h9, 4'h1, 4'hD, 4'hA, 4'h0},
    '{4'hC, 4'h9, 4'hF, 4'h4, 4'hB, 4'hE, 4'h1, 4'h2, 4'h0, 4'h3, 4'h6, 4'hD, 4'h5, 4'h8, 4'hA, 4'h7},
    '{4'h0, 4'h9, 4'hA, 4'h7, 4'hB, 4'hE, 4'h6, 4'hD, 4'h3, 4'h5, 4'hC, 4'h2, 4'h4, 4'h8, 4'hF, 4'h1},
    '{4'h5, 4'h0, 4'h8, 4'h3, 4'hA, 4'h9, 4'h7, 4'hE, 4'h2, 4'hC, 4'hB, 4'h6, 4'h4, 4'hF, 4'hD, 4'h1},
    '{4'h8, 4'hF, 4'h2, 4'h9, 4'h4, 4'h1, 4'hD, 4'hE, 4'hB, 4'h6, 4'h5, 4'h3, 4'h7, 4'hC, 4'hA, 4'h0},
    '{4'hF, 4'hA, 4'h1, 4'hD, 4'h5, 4'h3, 4'h6, 4'h0, 4'h4, 4'h9, 4'hE, 4'h7, 4'h2, 4'hC, 4'h8, 4'hB},
    '{4'h3, 4'h0, 4'h6, 4'hD, 4'h9, 4'hE, 4'hF, 4'h8, 4'h5, 4'hC, 4'hB, 4'h7, 4'hA, 4'h1, 4'h4, 4'h2}
  };

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } dec_state_e;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Words X0..X3 live at bits [31:0]..[127:96].
  function automatic logic [127:0] inv_lt(input logic [127:0] s);
    logic [31:0] x0, x1, x2, x3;
    x0 = s[31:0];
    x1 = s[63:32];
    x2 = s[95:64];
    x3 = s[127:96];
    x2 = rotr32(x2, INV_LT_ROT_X2_A);
    x0 = rotr32(x0, INV_LT_ROT_X0_A);
    x2 = x2 ^ x3 ^ (x1 << INV_LT_SHL_X1);
    x0 = x0 ^ x1 ^ x3;
    x3 = rotr32(x3, INV_LT_ROT_X3);
    x1 = rotr32(x1, INV_LT_ROT_X1);
    x3 = x3 ^ x2 ^ (x0 << INV_LT_SHL_X0);
    x1 = x1 ^ x0 ^ x2;
    x2 = rotr32(x2, INV_LT_ROT_X2_B);
    x0 = rotr32(x0, INV_LT_ROT_X0_B);
    return {x3, x2, x1, x0};
  endfunction

endpackage

// File: rtl/inv_s4_box_sel.sv
// Bitsliced inverse S-box layer: applies InvS<sel_i> to all 32 columns.
// Column i is the nibble {word3[i],word2[i],word1[i],word0[i]}.
//   sel_i  : inverse S-box number 0..7
//   data_i : 128-bit state, word k = bits [32k+31:32k]
//   data_o : substituted state, same layout
module inv_s4_box_sel
  import serpent_pkg::*;
(
  input  logic [2:0]   sel_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  for (genvar i = 0; i < 32; i++) begin : g_col
    logic [3:0] nib_in;
    logic [3:0] nib_out;
    assign nib_in       = {data_i[96+i], data_i[64+i], data_i[32+i], data_i[i]};
    assign nib_out      = INV_SBOX[sel_i][nib_in];
    assign data_o[i]    = nib_out[0];
    assign data_o[32+i] = nib_out[1];
    assign data_o[64+i] = nib_out[2];
    assign data_o[96+i] = nib_out[3];
  end

endmodule

// File: rtl/serpent_decrypt_core.sv
// Iterative Serpent block decryptor, one round per clock.
// A ciphertext is whitened with K32 on acceptance, then 32 ROUND cycles
// walk rnd = 31..0, each requesting K[rnd] on key_idx and sampling subkey
// in that same cycle. The plaintext is held in DONE until out_ready.
//   clk, rst_n  : clock, asynchronous active-low reset
//   abort       : (only with SERPENT_DEC_ABORT_EN) drop the in-flight block
//   in_valid    : ciphertext offered;   in_ready : core is IDLE
//   input_data  : 128-bit ciphertext
//   key_idx     : subkey index requested (32 idle, rnd in ROUND, 0 done)
//   subkey      : K[key_idx], combinational from the key store
//   out_valid   : plaintext available;  out_ready : consumer accepts
//   output_data : plaintext, zero while out_valid is low
// Optional feature macro: SERPENT_DEC_ABORT_EN.
module serpent_decrypt_core
  import serpent_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
`ifdef SERPENT_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] input_data,
  output logic [5:0]   key_idx,
  input  logic [127:0] subkey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] output_data
);

  localparam logic [4:0] RND_FIRST = 5'(NUM_ROUNDS - 1);
  localparam logic [5:0] KEY_WHITE = 6'(NUM_SUBKEYS - 1);

  dec_state_e   fsm_q;
  logic [4:0]   rnd_q;
  logic [127:0] state_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [5:0]   key_idx_q;

  logic         abort_req;
  logic [127:0] sbox_in_d;
  logic [127:0] sbox_out_d;
  logic [127:0] round_d;

`ifdef SERPENT_DEC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The first decrypt round has no inverse LT in front of its S-box.
  always_comb begin
    sbox_in_d = (rnd_q == RND_FIRST) ? state_q : inv_lt(state_q);
    round_d   = sbox_out_d ^ subkey;
  end

  inv_s4_box_sel u_inv_sbox (
    .sel_i  (rnd_q[2:0]),
    .data_i (sbox_in_d),
    .data_o (sbox_out_d)
  );

  // key_idx is registered alongside the state so it always names the
  // subkey the current state consumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      rnd_q       <= RND_FIRST;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      key_idx_q   <= KEY_WHITE;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= input_data ^ subkey;
            rnd_q      <= RND_FIRST;
            fsm_q      <= ROUND;
            in_ready_q <= 1'b0;
            key_idx_q  <= {1'b0, RND_FIRST};
          end
        end
        ROUND: begin
          if (abort_req) begin
            fsm_q      <= IDLE;
            rnd_q      <= RND_FIRST;
            in_ready_q <= 1'b1;
            key_idx_q  <= KEY_WHITE;
          end else begin
            state_q <= round_d;
            if (rnd_q == 5'd0) begin
              fsm_q       <= DONE;
              out_valid_q <= 1'b1;
              key_idx_q   <= 6'd0;
            end else begin
              rnd_q     <= rnd_q - 5'd1;
              key_idx_q <= {1'b0, rnd_q - 5'd1};
            end
          end
        end
        DONE: begin
          if (abort_req || out_ready) begin
            fsm_q       <= IDLE;
            rnd_q       <= RND_FIRST;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            key_idx_q   <= KEY_WHITE;
          end
        end
        default: begin
          fsm_q       <= IDLE;
          rnd_q       <= RND_FIRST;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          key_idx_q   <= KEY_WHITE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign key_idx     = key_idx_q;
  assign output_data = out_valid_q ? state_q : '0;

endmodule

// File: tb/tb_serpent_decrypt_core.sv
// Bench for serpent_decrypt_core: a forward Serpent model encrypts each
// plaintext, the ciphertext is fed to the core and the plaintext is queued
// as the expected result, popped when the core hands out its output.
module tb_serpent_decrypt_core;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] input_data;
  logic [5:0]   key_idx;
  logic [127:0] subkey;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] output_data;
`ifdef SERPENT_DEC_ABORT_EN
  logic         abort;
`endif

  logic [2:0]   box_sel;
  logic [127:0] box_in;
  logic [127:0] box_out;

  logic [127:0] keys [33];
  logic [127:0] exp_q [$];
  int unsigned  n_checks;
  int unsigned  n_errors;

  localparam logic [3:0] SBOX [8][16] = '{
    '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
    '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
    '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
    '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
    '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
    '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
    '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
    '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
  };

  serpent_decrypt_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SERPENT_DEC_ABORT_EN
    .abort       (abort),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_data  (input_data),
    .key_idx     (key_idx),
    .subkey      (subkey),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_data (output_data)
  );

  inv_s4_box_sel u_box (
    .sel_i  (box_sel),
    .data_i (box_in),
    .data_o (box_out)
  );

  // Key store: combinational read of the requested subkey.
  always_comb begin
    subkey = '0;
    if (key_idx < 6'd33) subkey = keys[key_idx];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] sbox_layer(input logic [127:0] x, input logic [2:0] s);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  o;
    w0 = x[31:0]; w1 = x[63:32]; w2 = x[95:64]; w3 = x[127:96];
    y0 = '0; y1 = '0; y2 = '0; y3 = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      o = SBOX[s][{w3[i[4:0]], w2[i[4:0]], w1[i[4:0]], w0[i[4:0]]}];
      y0[i[4:0]] = o[0];
      y1[i[4:0]] = o[1];
      y2[i[4:0]] = o[2];
      y3[i[4:0]] = o[3];
    end
    return {y3, y2, y1, y0};
  endfunction

  function automatic logic [127:0] lt(input logic [127:0] s);
    logic [31:0] x0, x1, x2, x3;
    x0 = s[31:0]; x1 = s[63:32]; x2 = s[95:64]; x3 = s[127:96];
    x0 = rotl(x0, 13);
    x2 = rotl(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] x;
    x = pt;
    for (int unsigned r = 0; r < 32; r++) begin
      x = sbox_layer(x ^ keys[r], r[2:0]);
      if (r < 31) x = lt(x);
      else        x = x ^ keys[32];
    end
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_keys(input bit zero);
    for (int unsigned k = 0; k < 33; k++) keys[k] = zero ? '0 : rand128();
  endtask

  // Caller is at a negedge with the core IDLE; returns at a negedge, IDLE.
  task automatic run_block(input logic [127:0] pt, input int unsigned stall, input bit junk);
    int unsigned n;
    input_data = encrypt(pt);
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", 128'(in_ready), 128'(1));
    check("key_idx_idle", 128'(key_idx), 128'(32));
    exp_q.push_back(pt);
    @(negedge clk);
    in_valid = junk;
    for (int unsigned k = 0; k < 32; k++) begin
      if (junk) input_data = rand128();
      check("key_idx_round", 128'(key_idx), 128'(31 - k));
      check("in_ready_round", 128'(in_ready), 128'(0));
      check("out_valid_round", 128'(out_valid), 128'(0));
      check("output_zero_round", output_data, '0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("out_valid_latency", 128'(out_valid), 128'(1));
    check("key_idx_done", 128'(key_idx), 128'(0));
    for (int unsigned s = 0; s < stall; s++) begin
      check("hold_data", output_data, exp_q[0]);
      check("hold_in_ready", 128'(in_ready), 128'(0));
      check("hold_out_valid", 128'(out_valid), 128'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (exp_q.size() == 0) check("scoreboard_empty", 128'(0), 128'(1));
    else                   check("plaintext", output_data, exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after", 128'(in_ready), 128'(1));
    check("out_valid_after", 128'(out_valid), 128'(0));
    check("output_zero_after", output_data, '0);
  endtask

  // Accepts a block and stops at the negedge where key_idx == target.
  task automatic start_and_reach(input logic [5:0] target);
    int unsigned n;
    input_data = encrypt(rand128());
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (key_idx != target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_round", 128'(key_idx), 128'(target));
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    input_data = '0;
    box_sel    = 3'd0;
    box_in     = '0;
`ifdef SERPENT_DEC_ABORT_EN
    abort      = 1'b0;
`endif
    set_keys(1'b1);
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_key_idx", 128'(key_idx), 128'(32));
    check("rst_output", output_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stand-alone inverse S-box layer.
    #1;
    check("box_sel0_zero", box_out, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF});
    box_sel = 3'd7;
    box_in  = '1;
    #1;
    check("box_sel7_ones", box_out, {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0});
    @(negedge clk);

    // All-zero subkeys, zero plaintext.
    run_block('0, 0, 1'b0);

    // Random subkeys, consumer stalls for 10 cycles.
    set_keys(1'b0);
    run_block(rand128(), 10, 1'b1);

    // Reset in the middle of the rounds discards the block.
    start_and_reach(6'd15);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_key_idx", 128'(key_idx), 128'(32));
    check("midrst_output", output_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 128'(in_ready), 128'(1));
    check("postrst_out_valid", 128'(out_valid), 128'(0));
    run_block(rand128(), 0, 1'b0);

`ifdef SERPENT_DEC_ABORT_EN
    start_and_reach(6'd20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_key_idx", 128'(key_idx), 128'(32));
    for (int unsigned c = 0; c < 40; c++) begin
      check("abort_no_output", 128'(out_valid), 128'(0));
      @(negedge clk);
    end
    run_block(rand128(), 0, 1'b0);
`endif

    // Bulk round trips with random plaintexts.
    for (int unsigned b = 0; b < 1000; b++) begin
      run_block(rand128(), $urandom_range(0, 2), b[0]);
    end

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
